// File: rtl/kernel_dispatch.sv
// kernel_dispatch: holds the thread-count DCR, splits the kernel into blocks and
// dispatches/retires blocks on the compute cores until every block has completed.
module kernel_dispatch #(
   parameter int NUM_CORES = 2,
   parameter int THREADS_PER_BLOCK = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   output logic                                done,
   input  logic                                device_control_write_enable,
   input  logic [7:0]                          device_control_data,
   output logic [7:0]                          thread_count,
   input  logic [NUM_CORES-1:0]                core_done,
   output logic [NUM_CORES-1:0]                core_start,
   output logic [NUM_CORES-1:0]                core_reset,
   output logic [7:0]                          core_block_id [NUM_CORES],
   output logic [$clog2(THREADS_PER_BLOCK):0]  core_thread_count [NUM_CORES]
);
   localparam int SH = $clog2(THREADS_PER_BLOCK);
   localparam int TW = SH + 1;
   logic                 start_execution;
   logic [7:0]           blocks_dispatched, blocks_done;
   logic [8:0]           total_blocks;
   logic [7:0]           bd_n, bdone_n;
   logic [NUM_CORES-1:0] start_n, reset_n;
   logic [7:0]           id_n [NUM_CORES];
   logic [TW-1:0]        cnt_n [NUM_CORES];
   assign total_blocks = ({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> SH;
   // cores are walked in index order so lower cores take lower block ids within a cycle
   always_comb begin
      bd_n = blocks_dispatched;
      bdone_n = blocks_done;
      start_n = core_start;
      reset_n = core_reset;
      id_n = core_block_id;
      cnt_n = core_thread_count;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_reset[i]) begin
            reset_n[i] = 1'b0;
            if ({1'b0, bd_n} < total_blocks) begin
               start_n[i] = 1'b1;
               id_n[i] = bd_n;
               cnt_n[i] = ({1'b0, bd_n} == total_blocks - 9'd1)
                  ? TW'(thread_count - 8'(bd_n * THREADS_PER_BLOCK)) : TW'(THREADS_PER_BLOCK);
               bd_n = bd_n + 8'd1;
            end
         end else if (core_start[i] && core_done[i]) begin
            reset_n[i] = 1'b1;
            start_n[i] = 1'b0;
            bdone_n = bdone_n + 8'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thread_count <= '0;
         done <= 1'b0;
         start_execution <= 1'b0;
         blocks_dispatched <= '0;
         blocks_done <= '0;
         core_start <= '0;
         core_reset <= '1;
         core_block_id <= '{default: '0};
         core_thread_count <= '{default: '0};
      end else begin
         if (device_control_write_enable && !(start_execution && !done))
            thread_count <= device_control_data;
         if (start) begin
            start_execution <= 1'b1;
            // completion is only recognised once the run has been latched, so an empty kernel finishes on the second edge
            if (start_execution && {1'b0, blocks_done} == total_blocks)
               done <= 1'b1;
            blocks_dispatched <= bd_n;
            blocks_done <= bdone_n;
            core_start <= start_n;
            core_reset <= reset_n;
            core_block_id <= id_n;
            core_thread_count <= cnt_n;
         end
      end
   end
endmodule

// File: tb/tb_kernel_dispatch.sv
// tb_kernel_dispatch: directed scenarios plus randomized runs checked against a
// block-queue reference model of the dispatcher.
module tb_kernel_dispatch;
   localparam int NC = 2;
   localparam int TPB = 4;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       we = 1'b0;
   logic [7:0] data = '0;
   logic       done;
   logic [7:0] thread_count;
   logic [NC-1:0] core_done = '0;
   logic [NC-1:0] core_start, core_reset;
   logic [7:0] core_block_id [NC];
   logic [2:0] core_thread_count [NC];
   int checks = 0;
   int errors = 0;
   // model: phase 0 = awaiting a block (held in reset), 1 = running a block, 2 = idle
   int m_tc, m_nb, m_next, m_retired;
   bit m_started, m_done;
   int m_phase [NC];
   int m_id [NC];
   int m_cnt [NC];

   kernel_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .device_control_write_enable(we), .device_control_data(data),
      .thread_count(thread_count), .core_done(core_done), .core_start(core_start),
      .core_reset(core_reset), .core_block_id(core_block_id),
      .core_thread_count(core_thread_count));

   always #5 clk = ~clk;

   task automatic model_reset();
      m_tc = 0; m_nb = 0; m_next = 0; m_retired = 0; m_started = 0; m_done = 0;
      for (int i = 0; i < NC; i++) begin
         m_phase[i] = 0; m_id[i] = 0; m_cnt[i] = 0;
      end
   endtask

   task automatic model_edge();
      int new_tc;
      new_tc = m_tc;
      if (we && !(m_started && !m_done)) new_tc = int'(data);
      if (start) begin
         if (m_started && m_retired == m_nb) m_done = 1;
         m_started = 1;
         for (int i = 0; i < NC; i++) begin
            if (m_phase[i] == 0) begin
               if (m_next < m_nb) begin
                  m_phase[i] = 1;
                  m_id[i] = m_next;
                  m_cnt[i] = (m_tc - m_next * TPB < TPB) ? m_tc - m_next * TPB : TPB;
                  m_next++;
               end else m_phase[i] = 2;
            end else if (m_phase[i] == 1 && core_done[i]) begin
               m_phase[i] = 0;
               m_retired++;
            end
         end
      end
      m_tc = new_tc;
      m_nb = (m_tc + TPB - 1) / TPB;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      start = 0; we = 0; core_done = '0;
      reset = 0;
      #2;
      model_reset();
      reset = 1;
   endtask

   task automatic write_dcr(input int v);
      we = 1; data = 8'(v);
      tick();
      we = 0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (done !== 1'b0 || core_start !== 2'b00 || core_reset !== 2'b11 || thread_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_ctrl: done %b start %b reset %b tc %0d, want 0 00 11 0", done, core_start, core_reset, thread_count);
      end
      checks++;
      if (core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd0 || core_thread_count[0] !== 3'd0 || core_thread_count[1] !== 3'd0) begin
         errors++;
         $display("FAIL reset_ids: ids %0d/%0d cnts %0d/%0d, want 0/0 0/0", core_block_id[0], core_block_id[1], core_thread_count[0], core_thread_count[1]);
      end
      model_reset();
      reset = 1;
   endtask

   task automatic test_eight_threads();
      apply_reset();
      write_dcr(8);
      checks++;
      if (thread_count !== 8'd8) begin
         errors++; $display("FAIL dcr_write: got %0d want 8", thread_count);
      end
      start = 1;
      tick();
      checks++;
      if (core_start !== 2'b11 || core_reset !== 2'b00 || core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd1
          || core_thread_count[0] !== 3'd4 || core_thread_count[1] !== 3'd4) begin
         errors++;
         $display("FAIL eight_dispatch: start %b reset %b ids %0d/%0d cnts %0d/%0d, want 11 00 0/1 4/4",
                  core_start, core_reset, core_block_id[0], core_block_id[1], core_thread_count[0], core_thread_count[1]);
      end
      core_done = 2'b11;
      tick();
      core_done = 2'b00;
      checks++;
      if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin
         errors++; $display("FAIL eight_retire: start %b reset %b done %b, want 00 11 0", core_start, core_reset, done);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL eight_done: got %b want 1", done);
      end
   endtask

   task automatic test_ten_threads();
      apply_reset();
      write_dcr(10);
      start = 1;
      tick();
      checks++;
      if (core_block_id[0] !== 8'd0 || core_block_id[1] !== 8'd1 || core_start !== 2'b11) begin
         errors++; $display("FAIL ten_first: ids %0d/%0d start %b, want 0/1 11", core_block_id[0], core_block_id[1], core_start);
      end
      core_done = 2'b10;
      tick();
      core_done = 2'b00;
      checks++;
      if (core_reset !== 2'b10 || core_start !== 2'b01) begin
         errors++; $display("FAIL ten_retire1: reset %b start %b, want 10 01", core_reset, core_start);
      end
      tick();
      checks++;
      if (core_start !== 2'b11 || core_block_id[1] !== 8'd2 || core_thread_count[1] !== 3'd2) begin
         errors++; $display("FAIL ten_redispatch: start %b id %0d cnt %0d, want 11 2 2", core_start, core_block_id[1], core_thread_count[1]);
      end
      core_done = 2'b01;
      tick();
      core_done = 2'b00;
      tick();
      checks++;
      if (done !== 1'b0 || core_start !== 2'b10) begin
         errors++; $display("FAIL ten_partial: done %b start %b, want 0 10", done, core_start);
      end
      core_done = 2'b10;
      tick();
      core_done = 2'b00;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL ten_early_done: got %b want 0", done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || core_start !== 2'b00) begin
         errors++; $display("FAIL ten_done: done %b start %b, want 1 00", done, core_start);
      end
   endtask

   task automatic test_zero_threads();
      apply_reset();
      start = 1;
      tick();
      checks++;
      if (done !== 1'b0 || core_start !== 2'b00 || core_reset !== 2'b00) begin
         errors++; $display("FAIL zero_first: done %b start %b reset %b, want 0 00 00", done, core_start, core_reset);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL zero_done: got %b want 1", done);
      end
      repeat (3) tick();
      checks++;
      if (core_start !== 2'b00 || done !== 1'b1) begin
         errors++; $display("FAIL zero_hold: start %b done %b, want 00 1", core_start, done);
      end
   endtask

   task automatic test_late_write();
      apply_reset();
      write_dcr(8);
      start = 1;
      tick();
      write_dcr(5);
      checks++;
      if (thread_count !== 8'd8) begin
         errors++; $display("FAIL late_write: got %0d want 8", thread_count);
      end
      apply_reset();
      write_dcr(5);
      checks++;
      if (thread_count !== 8'd5) begin
         errors++; $display("FAIL post_reset_write: got %0d want 5", thread_count);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      write_dcr(12);
      start = 1;
      tick();
      core_done = 2'b01;
      tick();
      core_done = 2'b00;
      tick();
      checks++;
      if (core_block_id[0] !== 8'd2 || core_start !== 2'b11) begin
         errors++; $display("FAIL mid_second_block: id %0d start %b, want 2 11", core_block_id[0], core_start);
      end
      #2;
      reset = 0;
      #1;
      checks++;
      if (done !== 1'b0 || core_reset !== 2'b11 || core_start !== 2'b00 || thread_count !== 8'd0 || core_block_id[0] !== 8'd0) begin
         errors++; $display("FAIL mid_async_reset: done %b reset %b start %b tc %0d id %0d, want 0 11 00 0 0",
                            done, core_reset, core_start, thread_count, core_block_id[0]);
      end
      apply_reset();
      write_dcr(4);
      start = 1;
      tick();
      checks++;
      if (core_start !== 2'b01 || core_block_id[0] !== 8'd0 || core_thread_count[0] !== 3'd4) begin
         errors++; $display("FAIL rerun_dispatch: start %b id %0d cnt %0d, want 01 0 4", core_start, core_block_id[0], core_thread_count[0]);
      end
      core_done = 2'b01;
      tick();
      core_done = 2'b00;
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL rerun_done: got %b want 1", done);
      end
   endtask

   task automatic test_held_start();
      apply_reset();
      write_dcr(8);
      start = 1;
      tick();
      start = 0;
      core_done = 2'b11;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (core_start !== 2'b11 || core_reset !== 2'b00 || done !== 1'b0) begin
            errors++; $display("FAIL held_start c%0d: start %b reset %b done %b, want 11 00 0", c, core_start, core_reset, done);
         end
      end
      start = 1;
      tick();
      core_done = 2'b00;
      checks++;
      if (core_start !== 2'b00 || core_reset !== 2'b11) begin
         errors++; $display("FAIL held_resume: start %b reset %b, want 00 11", core_start, core_reset);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int post;
         logic [NC-1:0] es, er;
         post = 0;
         apply_reset();
         write_dcr(r == 0 ? 255 : int'($urandom_range(0, 40)));
         for (int c = 0; c < 3000 && post < 4; c++) begin
            start = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 7) == 0);
            data = 8'($urandom_range(0, 40));
            for (int i = 0; i < NC; i++) core_done[i] = (m_phase[i] != 0) && ($urandom_range(0, 1) == 1);
            tick();
            for (int i = 0; i < NC; i++) begin
               es[i] = (m_phase[i] == 1);
               er[i] = (m_phase[i] == 0);
            end
            checks++;
            if (core_start !== es || core_reset !== er || done !== m_done || thread_count !== 8'(m_tc)) begin
               errors++;
               $display("FAIL rand_ctrl r%0d c%0d: start %b reset %b done %b tc %0d, want %b %b %b %0d",
                        r, c, core_start, core_reset, done, thread_count, es, er, m_done, m_tc);
            end
            for (int i = 0; i < NC; i++) begin
               checks++;
               if (core_block_id[i] !== 8'(m_id[i]) || core_thread_count[i] !== 3'(m_cnt[i])) begin
                  errors++;
                  $display("FAIL rand_block r%0d c%0d core%0d: id %0d cnt %0d, want %0d %0d",
                           r, c, i, core_block_id[i], core_thread_count[i], m_id[i], m_cnt[i]);
               end
            end
            if (m_done) post++;
         end
         we = 0;
         core_done = '0;
         checks++;
         if (post < 4) begin
            errors++; $display("FAIL rand_timeout r%0d: done %b, want 1 within budget", r, done);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_eight_threads();
      test_ten_threads();
      test_zero_threads();
      test_late_write();
      test_mid_reset();
      test_held_start();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
